mux_channel_arbiter: RTL and testbench

- Two-channel round-robin arbiter that sits directly upstream of the 8-bit 2:1 mux.
- Buffers one byte per input channel behind a valid/ready handshake.
- Drives the mux data inputs and select line, then registers the mux result into a valid/ready output stage.
- Keeps saturating per-channel grant counters for debug and bench checking.

---
 rtl/mux_channel_arbiter.sv | 129 ++++++++++++
 tb/tb_mux_channel_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_channel_arbiter.sv
// Two-channel round-robin arbiter feeding an external 2:1 mux; buffers one byte per
// channel, registers the mux result into a valid/ready output stage, counts grants.
module mux_channel_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_valid,
  output logic             in2_ready,
  output logic [WIDTH-1:0] mux_in1,
  output logic [WIDTH-1:0] mux_in2,
  output logic             mux_select,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] grant_cnt2
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_buf1;
  logic [WIDTH-1:0] r_buf2;
  logic             r_full1;
  logic             r_full2;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] r_cnt2;

  logic w_free;
  logic w_grant_vld;
  logic w_grant;
  logic w_grant1;
  logic w_grant2;

  // Arbitration: contention alternates on last_grant, arrival order is irrelevant
  always_comb begin
    w_free      = !r_out_valid || out_ready;
    w_grant_vld = w_free && (r_full1 || r_full2);
    w_grant     = 1'b0;
    if (r_full1 && r_full2) begin
      w_grant = !r_last_grant;
    end else if (r_full2) begin
      w_grant = 1'b1;
    end
    w_grant1 = w_grant_vld && !w_grant;
    w_grant2 = w_grant_vld && w_grant;
  end

  // Channel 1 holding register; a drained buffer only reopens on the next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf1  <= '0;
      r_full1 <= 1'b0;
    end else if (w_grant1) begin
      r_full1 <= 1'b0;
    end else if (in1_valid && !r_full1) begin
      r_buf1  <= in1_data;
      r_full1 <= 1'b1;
    end
  end

  // Channel 2 holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf2  <= '0;
      r_full2 <= 1'b0;
    end else if (w_grant2) begin
      r_full2 <= 1'b0;
    end else if (in2_valid && !r_full2) begin
      r_buf2  <= in2_data;
      r_full2 <= 1'b1;
    end
  end

  // Output stage and round-robin history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data   <= '0;
      r_out_src    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_grant_vld) begin
      r_out_data   <= mux_out;
      r_out_src    <= w_grant;
      r_out_valid  <= 1'b1;
      r_last_grant <= w_grant;
    end else if (w_free && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Saturating grant counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt1 <= '0;
      r_cnt2 <= '0;
    end else begin
      if (w_grant1 && (r_cnt1 != CNT_MAX)) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
      if (w_grant2 && (r_cnt2 != CNT_MAX)) begin
        r_cnt2 <= r_cnt2 + CNT_W'(1);
      end
    end
  end

  assign in1_ready  = !r_full1;
  assign in2_ready  = !r_full2;
  assign mux_in1    = r_buf1;
  assign mux_in2    = r_buf2;
  assign mux_select = w_grant2;
  assign out_data   = r_out_data;
  assign out_src    = r_out_src;
  assign out_valid  = r_out_valid;
  assign grant_cnt1 = r_cnt1;
  assign grant_cnt2 = r_cnt2;

endmodule

// File: tb/tb_mux_channel_arbiter.sv
// Directed bench for mux_channel_arbiter: a vector table for the basic handshake plus
// hand-written sequences for alternation, stalls, saturation, reset and ignored payloads.
module tb_mux_channel_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in1_data;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in2_data;
  logic             in2_valid;
  logic             in2_ready;
  logic [WIDTH-1:0] mux_in1;
  logic [WIDTH-1:0] mux_in2;
  logic             mux_select;
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] grant_cnt1;
  logic [CNT_W-1:0] grant_cnt2;

  int n_vec;
  int n_err;

  mux_channel_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in2_data   (in2_data),
    .in2_valid  (in2_valid),
    .in2_ready  (in2_ready),
    .mux_in1    (mux_in1),
    .mux_in2    (mux_in2),
    .mux_select (mux_select),
    .mux_out    (mux_out),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant_cnt1 (grant_cnt1),
    .grant_cnt2 (grant_cnt2)
  );

  // Behavioural model of the downstream 2:1 mux
  assign mux_out = mux_select ? mux_in2 : mux_in1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v1;
    logic [7:0] d1;
    logic       v2;
    logic [7:0] d2;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_src;
    logic       e_r1;
    logic       e_r2;
    logic       e_sel;
    logic [7:0] e_c1;
    logic [7:0] e_c2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    in1_data  = '0;
    in2_data  = '0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
  endtask

  // Loads AA/55, grants AA with out_ready low, refills ch1 with 77: both full, output stalled
  task automatic setup_stall();
    do_reset();
    in1_valid = 1'b1; in1_data = 8'hAA;
    in2_valid = 1'b1; in2_data = 8'h55;
    tick();
    chk("stall_load_r1", 32'(in1_ready), 32'd0);
    chk("stall_load_sel", 32'(mux_select), 32'd0);
    tick();
    chk("stall_first_od", 32'(out_data), 32'hAA);
    in1_data = 8'h77;
    tick();
    in1_valid = 1'b0;
    in2_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int   n_out;
    int   edges;
    int   gap_err;

    n_vec = 0;
    n_err = 0;

    // Reset state
    do_reset();
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'd0);
    chk("rst_r1", 32'(in1_ready), 32'd1);
    chk("rst_r2", 32'(in2_ready), 32'd1);
    chk("rst_c1", 32'(grant_cnt1), 32'd0);

    // Simultaneous load of AA/55: ch1 wins first, then ch2 on the next cycle
    //            v1  d1     v2  d2     rdy  ov  od     src  r1  r2  sel  c1 c2
    vecs[0] = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1};
    for (int i = 0; i < 4; i++) begin
      in1_valid = vecs[i].v1; in1_data = vecs[i].d1;
      in2_valid = vecs[i].v2; in2_data = vecs[i].d2;
      out_ready = vecs[i].ordy;
      tick();
      chk($sformatf("vec%0d_ov", i),  32'(out_valid),  32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_od", i),  32'(out_data),   32'(vecs[i].e_od));
      chk($sformatf("vec%0d_src", i), 32'(out_src),    32'(vecs[i].e_src));
      chk($sformatf("vec%0d_r1", i),  32'(in1_ready),  32'(vecs[i].e_r1));
      chk($sformatf("vec%0d_r2", i),  32'(in2_ready),  32'(vecs[i].e_r2));
      chk($sformatf("vec%0d_sel", i), 32'(mux_select), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d_c1", i),  32'(grant_cnt1), 32'(vecs[i].e_c1));
      chk($sformatf("vec%0d_c2", i),  32'(grant_cnt2), 32'(vecs[i].e_c2));
    end

    // Both channels held valid: strict alternation, one output per cycle
    do_reset();
    in1_valid = 1'b1; in1_data = 8'h3C;
    in2_valid = 1'b1; in2_data = 8'hC3;
    out_ready = 1'b1;
    n_out = 0;
    edges = 0;
    while (n_out < 10 && edges < 40) begin
      tick();
      edges++;
      if (out_valid) begin
        chk($sformatf("alt%0d_src", n_out), 32'(out_src), 32'(n_out % 2));
        chk($sformatf("alt%0d_od", n_out), 32'(out_data), (n_out % 2 == 1) ? 32'hC3 : 32'h3C);
        n_out++;
      end
    end
    chk("alt_edges", 32'(edges), 32'd11);
    chk("alt_c1", 32'(grant_cnt1), 32'd5);
    chk("alt_c2", 32'(grant_cnt2), 32'd5);

    // Output stall with both buffers full, then round-robin drain
    setup_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_od", i), 32'(out_data), 32'hAA);
      chk($sformatf("hold%0d_ov", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_r1", i), 32'(in1_ready), 32'd0);
      chk($sformatf("hold%0d_r2", i), 32'(in2_ready), 32'd0);
      chk($sformatf("hold%0d_sel", i), 32'(mux_select), 32'd0);
      chk($sformatf("hold%0d_c1", i), 32'(grant_cnt1), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("drain0_od", 32'(out_data), 32'h55);
    chk("drain0_src", 32'(out_src), 32'd1);
    tick();
    chk("drain1_od", 32'(out_data), 32'h77);
    chk("drain1_src", 32'(out_src), 32'd0);
    tick();
    chk("drain_idle_ov", 32'(out_valid), 32'd0);
    chk("drain_c1", 32'(grant_cnt1), 32'd2);
    chk("drain_c2", 32'(grant_cnt2), 32'd1);

    // Single channel: one grant every 2nd cycle, counter saturates at 255
    do_reset();
    in1_valid = 1'b1; in1_data = 8'h42;
    out_ready = 1'b1;
    gap_err = 0;
    for (int e = 1; e <= 600; e++) begin
      tick();
      if (out_valid !== ((e % 2) == 0)) gap_err++;
      if (e == 510) chk("sat_c1_at_255", 32'(grant_cnt1), 32'd255);
    end
    in1_valid = 1'b0;
    chk("single_gap_err", 32'(gap_err), 32'd0);
    chk("sat_c1_hold", 32'(grant_cnt1), 32'd255);
    chk("sat_c2", 32'(grant_cnt2), 32'd0);
    chk("single_od", 32'(out_data), 32'h42);

    // Asynchronous reset mid-cycle while stalled with both buffers full
    setup_stall();
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_od", 32'(out_data), 32'd0);
    chk("arst_src", 32'(out_src), 32'd0);
    chk("arst_r1", 32'(in1_ready), 32'd1);
    chk("arst_r2", 32'(in2_ready), 32'd1);
    chk("arst_c1", 32'(grant_cnt1), 32'd0);
    chk("arst_mux_in2", 32'(mux_in2), 32'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("arst_no_replay", 32'(out_valid), 32'd0);
    in1_valid = 1'b1; in1_data = 8'h11;
    in2_valid = 1'b1; in2_data = 8'h22;
    tick();
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    chk("arst_first_sel", 32'(mux_select), 32'd0);
    tick();
    chk("arst_first_src", 32'(out_src), 32'd0);
    chk("arst_first_od", 32'(out_data), 32'h11);

    // in2_valid pulse with FF while ch2 is full is ignored
    do_reset();
    out_ready = 1'b1;
    in2_valid = 1'b1; in2_data = 8'h5A;
    tick();
    in2_data = 8'hFF;
    chk("ign_r2", 32'(in2_ready), 32'd0);
    tick();
    in2_valid = 1'b0;
    chk("ign_od", 32'(out_data), 32'h5A);
    chk("ign_src", 32'(out_src), 32'd1);
    chk("ign_mux_in2", 32'(mux_in2), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
